// File: rtl/data_types.sv
// Shared types for the memory port arbiter: 32-bit data words, response
// ownership tags and a flush helper used by the tag pipeline.
package data_types;

  typedef logic [31:0] word32_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  localparam int         STARVE_CNT_W = 4;
  localparam logic [3:0] BE_FULL      = 4'hF;

  // A fetch-owned tag loses its owner when a mispredict flush is seen.
  function automatic owner_e flush_filter(input owner_e owner, input logic flush_if);
    return (flush_if && owner == OWN_IF) ? OWN_NONE : owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// Fixed-latency owner tag pipeline: entry 0 captures the owner of the access
// accepted this cycle, the tail names the requester of the data on mem_rdata_i.
module resp_tag_pipe
  import data_types::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic   clk_i,
  input  logic   reset_ni,
  input  owner_e push_i,
  input  logic   flush_if_i,
  output owner_e tail_o
);

  owner_e tags_q [MEM_LATENCY];
  owner_e tags_d [MEM_LATENCY];

  // NOTE: every element is assigned before any condition, so no latch is
  // inferred for the next-state array.
  always_comb begin
    tags_d[0] = flush_filter(push_i, flush_if_i);
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tags_d[i] = flush_filter(tags_q[i-1], flush_if_i);
    end
  end

  // NOTE: this small storage array is reset on purpose: stale OWN_IF/OWN_LS
  // tags would turn memory data arriving after reset into bogus responses.
  // NOTE: state is updated with non-blocking assignments so every stage
  // shifts from the pre-edge value of its neighbour.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tags_q[i] <= OWN_NONE;
      end
    end else begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tags_q[i] <= tags_d[i];
      end
    end
  end

  assign tail_o = tags_q[MEM_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and the LSU:
// LSU priority with a fetch anti-starvation override, tag-routed read data.
module mem_port_arbiter
  import data_types::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 3
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  // instruction fetch
  input  logic       if_req_i,
  input  word32_t    if_addr_i,
  input  logic       if_flush_i,
  output logic       if_gnt_o,
  output logic       if_rvalid_o,
  output word32_t    if_rdata_o,
  // load/store unit
  input  logic       ls_req_i,
  input  logic       ls_we_i,
  input  word32_t    ls_addr_i,
  input  word32_t    ls_wdata_i,
  input  logic [3:0] ls_be_i,
  output logic       ls_gnt_o,
  output logic       ls_rvalid_o,
  output word32_t    ls_rdata_o,
  // memory macro
  output logic       mem_req_o,
  output logic       mem_we_o,
  output word32_t    mem_addr_o,
  output word32_t    mem_wdata_o,
  output logic [3:0] mem_be_o,
  input  logic       mem_ready_i,
  input  word32_t    mem_rdata_i
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic   if_elig, ls_elig, if_starved;
  owner_e winner;
  owner_e push_owner;
  owner_e tail_owner;

  assign if_elig    = if_req_i & ~if_flush_i;
  assign ls_elig    = ls_req_i;
  assign if_starved = (starve_cnt_q == STARVE_LIM);

  always_comb begin
    winner = OWN_NONE;
    if (if_elig && (if_starved || !ls_elig)) begin
      winner = OWN_IF;
    end else if (ls_elig) begin
      winner = OWN_LS;
    end
  end

  // Request and grants are forced low while reset is held.
  assign mem_req_o = (if_elig | ls_elig) & reset_ni;
  assign if_gnt_o  = (winner == OWN_IF) & mem_ready_i & reset_ni;
  assign ls_gnt_o  = (winner == OWN_LS) & mem_ready_i & reset_ni;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = BE_FULL;
    unique case (winner)
      OWN_IF: begin
        mem_addr_o = if_addr_i;
      end
      OWN_LS: begin
        mem_we_o    = ls_we_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
        mem_be_o    = ls_we_i ? ls_be_i : BE_FULL;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt_o) begin
      starve_cnt_d = '0;
    end else if (if_elig && !if_starved) begin
      starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Stores never return data, so only reads leave an owner in the pipeline.
  always_comb begin
    push_owner = OWN_NONE;
    if (if_gnt_o) begin
      push_owner = OWN_IF;
    end else if (ls_gnt_o && !ls_we_i) begin
      push_owner = OWN_LS;
    end
  end

  resp_tag_pipe #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_resp_tag_pipe (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .push_i     (push_owner),
    .flush_if_i (if_flush_i),
    .tail_o     (tail_owner)
  );

  assign if_rvalid_o = (tail_owner == OWN_IF) & ~if_flush_i;
  assign ls_rvalid_o = (tail_owner == OWN_LS);
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_MAX=3): reset,
// routing, stores, contention, flush, backpressure and async reset.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
  logic [3:0]  ls_be_i, mem_be_o;
  logic        mem_req_o, mem_we_o, mem_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .MEM_LATENCY (2),
    .STARVE_MAX  (3)
  ) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_flush_i  (if_flush_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .ls_req_i    (ls_req_i),
    .ls_we_i     (ls_we_i),
    .ls_addr_i   (ls_addr_i),
    .ls_wdata_i  (ls_wdata_i),
    .ls_be_i     (ls_be_i),
    .ls_gnt_o    (ls_gnt_o),
    .ls_rvalid_o (ls_rvalid_o),
    .ls_rdata_o  (ls_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    if_flush_i = 1'b0;
    ls_req_i   = 1'b0;
    ls_we_i    = 1'b0;
    ls_addr_i  = '0;
    ls_wdata_i = '0;
    ls_be_i    = 4'h0;
  endtask

  initial begin
    bit exp_if;

    // ---- reset: outputs quiet even with both requesters active
    reset_ni    = 1'b0;
    idle();
    if_req_i    = 1'b1;
    ls_req_i    = 1'b1;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h0;
    #3;
    check("rst_if_gnt",    32'(if_gnt_o),    32'd0);
    check("rst_ls_gnt",    32'(ls_gnt_o),    32'd0);
    check("rst_mem_req",   32'(mem_req_o),   32'd0);
    check("rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
    check("rst_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #4;
    idle();
    reset_ni = 1'b1;
    tick();

    // ---- latency routing: fetch 0x40, data returns two cycles later
    if_req_i = 1'b1; if_addr_i = 32'h40;
    #2;
    check("lat_if_gnt",   32'(if_gnt_o), 32'd1);
    check("lat_mem_addr", mem_addr_o,    32'h40);
    check("lat_mem_we",   32'(mem_we_o), 32'd0);
    check("lat_mem_be",   32'(mem_be_o), 32'hF);
    tick();
    idle();
    #2;
    check("lat_t1_if_rvalid", 32'(if_rvalid_o), 32'd0);
    tick();
    mem_rdata_i = 32'h00A00093;
    #2;
    check("lat_t2_if_rvalid", 32'(if_rvalid_o), 32'd1);
    check("lat_t2_if_rdata",  if_rdata_o,       32'h00A00093);
    check("lat_t2_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    tick();
    mem_rdata_i = 32'hDEAD_0000;
    #2;
    check("lat_t3_if_rvalid", 32'(if_rvalid_o), 32'd0);

    // ---- store: byte-enabled write, no response
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h100;
    ls_wdata_i = 32'hBEEF; ls_be_i = 4'b0011;
    #2;
    check("st_ls_gnt",    32'(ls_gnt_o),  32'd1);
    check("st_mem_we",    32'(mem_we_o),  32'd1);
    check("st_mem_be",    32'(mem_be_o),  32'h3);
    check("st_mem_wdata", mem_wdata_o,    32'hBEEF);
    check("st_mem_addr",  mem_addr_o,     32'h100);
    tick();
    idle();
    tick();
    #2;
    check("st_t2_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    check("st_t2_if_rvalid", 32'(if_rvalid_o), 32'd0);
    tick();

    // ---- contention: LS,LS,LS,IF repeating; responses follow two cycles later
    for (int i = 0; i < 8; i++) begin
      if_req_i = 1'b1; if_addr_i = 32'h1000;
      ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h2000;
      mem_rdata_i = 32'hC000_0000 + i;
      #2;
      exp_if = (i % 4 == 3);
      check($sformatf("cont%0d_if_gnt", i), 32'(if_gnt_o), 32'(exp_if));
      check($sformatf("cont%0d_ls_gnt", i), 32'(ls_gnt_o), 32'(!exp_if));
      check($sformatf("cont%0d_addr", i), mem_addr_o, exp_if ? 32'h1000 : 32'h2000);
      if (i >= 2) begin
        check($sformatf("cont%0d_ls_rvalid", i), 32'(ls_rvalid_o), 32'(((i - 2) % 4) != 3));
        check($sformatf("cont%0d_if_rvalid", i), 32'(if_rvalid_o), 32'(((i - 2) % 4) == 3));
      end
      tick();
    end
    idle();
    mem_rdata_i = 32'hC000_0008;
    #2;
    check("drain0_ls_rvalid", 32'(ls_rvalid_o), 32'd1);
    check("drain0_ls_rdata",  ls_rdata_o,       32'hC000_0008);
    tick();
    mem_rdata_i = 32'hC000_0009;
    #2;
    check("drain1_if_rvalid", 32'(if_rvalid_o), 32'd1);
    check("drain1_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    tick();

    // ---- flush: in-flight fetch dropped, LSU load still returns
    if_req_i = 1'b1; if_addr_i = 32'h200;
    #2;
    check("fl_t0_if_gnt", 32'(if_gnt_o), 32'd1);
    tick();
    if_addr_i = 32'h204; if_flush_i = 1'b1;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h300;
    #2;
    check("fl_t1_if_gnt",   32'(if_gnt_o),  32'd0);
    check("fl_t1_ls_gnt",   32'(ls_gnt_o),  32'd1);
    check("fl_t1_mem_addr", mem_addr_o,     32'h300);
    tick();
    idle();
    #2;
    check("fl_t2_if_rvalid", 32'(if_rvalid_o), 32'd0);
    tick();
    if_flush_i = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    #2;
    check("fl_t3_if_rvalid", 32'(if_rvalid_o), 32'd0);
    check("fl_t3_ls_rvalid", 32'(ls_rvalid_o), 32'd1);
    check("fl_t3_ls_rdata",  ls_rdata_o,       32'h1234_5678);
    tick();
    idle();
    if_req_i = 1'b1; if_addr_i = 32'h208;
    #2;
    check("fl_u0_if_gnt", 32'(if_gnt_o), 32'd1);
    tick();
    idle();
    tick();
    if_flush_i = 1'b1;
    #2;
    check("fl_u2_tail_suppressed", 32'(if_rvalid_o), 32'd0);
    tick();
    idle();
    #2;
    check("fl_u3_if_rvalid", 32'(if_rvalid_o), 32'd0);
    tick();

    // ---- backpressure: no grants, fetch wins once ready rises
    mem_ready_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h500;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h400;
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("bp%0d_mem_req", i), 32'(mem_req_o), 32'd1);
      check($sformatf("bp%0d_if_gnt", i),  32'(if_gnt_o),  32'd0);
      check($sformatf("bp%0d_ls_gnt", i),  32'(ls_gnt_o),  32'd0);
      tick();
    end
    mem_ready_i = 1'b1;
    #2;
    check("bp_rise_if_gnt",   32'(if_gnt_o), 32'd1);
    check("bp_rise_ls_gnt",   32'(ls_gnt_o), 32'd0);
    check("bp_rise_mem_addr", mem_addr_o,    32'h500);
    tick();
    if_req_i = 1'b0;
    #2;
    check("bp_next_ls_gnt", 32'(ls_gnt_o), 32'd1);
    tick();
    #2;
    check("bp_ls2_ls_gnt",    32'(ls_gnt_o),    32'd1);
    check("bp_ls2_if_rvalid", 32'(if_rvalid_o), 32'd1);
    tick();

    // ---- async reset mid-burst
    #2;
    check("ar_pre_ls_rvalid", 32'(ls_rvalid_o), 32'd1);
    check("ar_pre_ls_gnt",    32'(ls_gnt_o),    32'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    check("ar_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    check("ar_ls_gnt",    32'(ls_gnt_o),    32'd0);
    check("ar_if_gnt",    32'(if_gnt_o),    32'd0);
    check("ar_mem_req",   32'(mem_req_o),   32'd0);
    @(posedge clk_i);
    #3;
    idle();
    reset_ni = 1'b1;
    tick();
    mem_rdata_i = 32'hBAD0_BAD0;
    #2;
    check("ar_r0_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    check("ar_r0_if_rvalid", 32'(if_rvalid_o), 32'd0);
    tick();
    #2;
    check("ar_r1_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    check("ar_r1_if_rvalid", 32'(if_rvalid_o), 32'd0);
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h600;
    #2;
    check("ar_new_if_gnt", 32'(if_gnt_o), 32'd1);
    tick();
    idle();
    tick();
    mem_rdata_i = 32'h0000_0613;
    #2;
    check("ar_new_if_rvalid", 32'(if_rvalid_o), 32'd1);
    check("ar_new_if_rdata",  if_rdata_o,       32'h0000_0613);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
